// File: rtl/vram_porta_arb.sv
// vram_porta_arb: arbitrates CPU and debug requesters onto VRAM port A.
// One access in flight at a time; writes take 2 cycles, reads 3.
// Optional macro VRAM_ARB_FAIRNESS_EN: after STARVE_MAX consecutive CPU grants
// while DBG waits, the next arbitration goes to DBG. Undefined: strict CPU priority.
module vram_porta_arb #(
  parameter int unsigned RAM_SIZE   = 21504,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic        clk_a,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [14:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dbg_req,
  input  logic        dbg_wr,
  input  logic [14:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic [14:0] address_a,
  output logic [31:0] data_a,
  output logic        wren_a,
  output logic        rden_a,
  input  logic [31:0] q_a
);

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  state_t              state;
  logic                sel_dbg;
  logic                lat_wr;
  logic                lat_ok;

  logic                starved_c;
  logic                grant_cpu_c;
  logic                grant_dbg_c;
  logic                win_wr_c;
  logic                win_ok_c;
  logic [ADDR_W-1:0]   win_addr_c;
  logic [DATA_W-1:0]   win_wdata_c;

`ifdef VRAM_ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign starved_c = (starve_cnt >= CNT_W'(STARVE_MAX));

  // Count CPU wins while DBG is waiting; any DBG win or DBG idle clears it.
  always_ff @(posedge clk_a) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!dbg_req || grant_dbg_c) begin
        starve_cnt <= '0;
      end else if (grant_cpu_c && !starved_c) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign starved_c = 1'b0;
`endif

  // Arbitration and winner mux; only consumed in IDLE.
  always_comb begin
    grant_dbg_c = dbg_req && (!cpu_req || starved_c);
    grant_cpu_c = cpu_req && !grant_dbg_c;
    win_wr_c    = grant_dbg_c ? dbg_wr    : cpu_wr;
    win_addr_c  = grant_dbg_c ? dbg_addr  : cpu_addr;
    win_wdata_c = grant_dbg_c ? dbg_wdata : cpu_wdata;
    win_ok_c    = (32'(win_addr_c) < RAM_SIZE);
  end

  // Access sequencer: IDLE grants, ACCESS drives the port, RDWAIT returns data.
  always_ff @(posedge clk_a) begin
    if (reset) begin
      state      <= IDLE;
      sel_dbg    <= 1'b0;
      lat_wr     <= 1'b0;
      lat_ok     <= 1'b0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      address_a  <= '0;
      data_a     <= '0;
      wren_a     <= 1'b0;
      rden_a     <= 1'b0;
    end else begin
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      wren_a     <= 1'b0;
      rden_a     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_cpu_c || grant_dbg_c) begin
            sel_dbg   <= grant_dbg_c;
            lat_wr    <= win_wr_c;
            lat_ok    <= win_ok_c;
            address_a <= win_addr_c;
            data_a    <= win_wdata_c;
            wren_a    <= win_wr_c && win_ok_c;
            rden_a    <= !win_wr_c && win_ok_c;
            cpu_ack   <= grant_cpu_c;
            dbg_ack   <= grant_dbg_c;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          state <= lat_wr ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          // Out-of-range reads never touched the RAM, so return zero.
          if (sel_dbg) begin
            dbg_rdata  <= lat_ok ? q_a : '0;
            dbg_rvalid <= 1'b1;
          end else begin
            cpu_rdata  <= lat_ok ? q_a : '0;
            cpu_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_porta_arb.sv
// Directed self-checking bench for vram_porta_arb with a behavioural port-A RAM.
module tb_vram_porta_arb;

  logic        clk_a = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr, dbg_req, dbg_wr;
  logic [14:0] cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic        cpu_ack, cpu_rvalid, dbg_ack, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic [14:0] address_a;
  logic [31:0] data_a, q_a;
  logic        wren_a, rden_a;

  logic [31:0] mem [0:32767];

  int n_checks = 0;
  int n_pass   = 0;

  vram_porta_arb dut (
    .clk_a(clk_a), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a),
    .q_a(q_a)
  );

  always #5 clk_a = ~clk_a;

  // Port-A RAM model: registered read, one-cycle latency.
  always @(posedge clk_a) begin
    if (wren_a) mem[address_a] <= data_a;
    if (rden_a) q_a <= mem[address_a];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk_a);
  endtask

  task automatic set_req(input bit is_dbg, input bit req, input bit wr,
                         input logic [14:0] a, input logic [31:0] d);
    if (is_dbg) begin
      dbg_req = req; dbg_wr = wr; dbg_addr = a; dbg_wdata = d;
    end else begin
      cpu_req = req; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  // One complete transaction from an IDLE cycle; returns in the next IDLE cycle.
  task automatic do_txn(input bit is_dbg, input bit wr, input logic [14:0] a,
                        input logic [31:0] d, input bit ok, input logic [31:0] exp_rd);
    set_req(is_dbg, 1'b1, wr, a, d);
    tick();
    check("ack_sel",   32'(is_dbg ? dbg_ack : cpu_ack), 32'd1);
    check("ack_other", 32'(is_dbg ? cpu_ack : dbg_ack), 32'd0);
    check("wren",      32'(wren_a), 32'(wr && ok));
    check("rden",      32'(rden_a), 32'(!wr && ok));
    if (ok) check("addr", 32'(address_a), 32'(a));
    if (ok && wr) check("wdata", data_a, d);
    set_req(is_dbg, 1'b0, wr, a, d);
    tick();
    check("ack_clear",  32'({cpu_ack, dbg_ack}), 32'd0);
    check("port_idle",  32'({wren_a, rden_a}), 32'd0);
    check("rvalid_early", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
    if (ok) check("addr_hold", 32'(address_a), 32'(a));
    if (!wr) begin
      tick();
      check("rvalid", 32'({cpu_rvalid, dbg_rvalid}), is_dbg ? 32'd1 : 32'd2);
      check("rdata",  is_dbg ? dbg_rdata : cpu_rdata, exp_rd);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 15'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 15'd0, 32'd0);
    tick();
    tick();
    check("rst_acks",   32'({cpu_ack, dbg_ack}), 32'd0);
    check("rst_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
    check("rst_port",   32'({wren_a, rden_a}), 32'd0);
    check("rst_addr",   32'(address_a), 32'd0);
    check("rst_data",   data_a, 32'd0);
    check("rst_cpu_rd", cpu_rdata, 32'd0);
    check("rst_dbg_rd", dbg_rdata, 32'd0);
    reset = 1'b0;
    tick();

    // CPU write then read-back
    do_txn(1'b0, 1'b1, 15'h0010, 32'hDEADBEEF, 1'b1, 32'd0);
    tick();
    check("wr_no_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
    do_txn(1'b0, 1'b0, 15'h0010, 32'd0, 1'b1, 32'hDEADBEEF);
    tick();
    check("rvalid_pulse", 32'(cpu_rvalid), 32'd0);
    check("cpu_rd_hold",  cpu_rdata, 32'hDEADBEEF);

    // DBG write/read, then out-of-range read
    do_txn(1'b1, 1'b1, 15'h0020, 32'h12345678, 1'b1, 32'd0);
    do_txn(1'b1, 1'b0, 15'h0020, 32'd0, 1'b1, 32'h12345678);
    do_txn(1'b1, 1'b0, 15'h5400, 32'd0, 1'b0, 32'd0);
    check("cpu_rd_kept", cpu_rdata, 32'hDEADBEEF);

    // Back-to-back CPU writes with req held
    set_req(1'b0, 1'b1, 1'b1, 15'h0100, 32'hA0000000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b2b_ack",  32'(cpu_ack), 32'd1);
      check("b2b_addr", 32'(address_a), 32'h100 + 32'(i));
      check("b2b_data", data_a, 32'hA0000000 + 32'(i));
      if (i < 2) set_req(1'b0, 1'b1, 1'b1, 15'(32'h101 + 32'(i)), 32'hA0000001 + 32'(i));
      else       set_req(1'b0, 1'b0, 1'b0, 15'd0, 32'd0);
      tick();
      check("b2b_gap", 32'(cpu_ack), 32'd0);
    end

    // Continuous contention from both requesters
    set_req(1'b0, 1'b1, 1'b1, 15'h0030, 32'h0000C0C0);
    set_req(1'b1, 1'b1, 1'b1, 15'h0031, 32'h0000D0D0);
    for (int k = 1; k <= 12; k++) begin
      bit exp_dbg, exp_cpu;
      tick();
      exp_dbg = 1'b0;
      exp_cpu = 1'b0;
      if (k % 2 == 1) begin
`ifdef VRAM_ARB_FAIRNESS_EN
        exp_dbg = (((k - 1) / 2) % 3 == 2);
`endif
        exp_cpu = !exp_dbg;
      end
      check("cont_cpu_ack", 32'(cpu_ack), 32'(exp_cpu));
      check("cont_dbg_ack", 32'(dbg_ack), 32'(exp_dbg));
    end
    set_req(1'b0, 1'b0, 1'b0, 15'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 15'd0, 32'd0);
    tick();

    // Reset during RDWAIT of a CPU read
    set_req(1'b0, 1'b1, 1'b0, 15'h0010, 32'd0);
    tick();
    check("rst_rd_ack", 32'(cpu_ack), 32'd1);
    set_req(1'b0, 1'b0, 1'b0, 15'd0, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("abort_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
    check("abort_acks",   32'({cpu_ack, dbg_ack, wren_a, rden_a}), 32'd0);
    check("abort_addr",   32'(address_a), 32'd0);
    check("abort_data",   data_a, 32'd0);
    check("abort_rdata",  cpu_rdata, 32'd0);
    reset = 1'b0;
    tick();
    check("abort_late_rvalid", 32'(cpu_rvalid), 32'd0);

    // Fresh traffic after reset
    do_txn(1'b0, 1'b1, 15'h0040, 32'hCAFEF00D, 1'b1, 32'd0);
    do_txn(1'b0, 1'b0, 15'h0040, 32'd0, 1'b1, 32'hCAFEF00D);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
